// File: rtl/watch2count.sv
// Watch time (hr:min:s.ms) to flat millisecond count, start/done handshake, fixed 3-cycle latency.
// Optional `WATCH2COUNT_SATURATE_EN: an out-of-range result saturates count instead of truncating it.
module watch2count #(
    parameter int BITS = 26
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [9:0]      ms,
    input  logic [5:0]      s,
    input  logic [5:0]      min,
    input  logic [3:0]      hr,
    output logic [BITS-1:0] count,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            ovf
);

    // 26 bits hold 15:63:63.1023, the largest value the field widths can express.
    localparam int AW = 26;
    typedef logic [AW-1:0] acc_t;

    typedef enum logic [1:0] {
        IDLE,
        HM,
        HMS,
        MSEC
    } state_t;

    state_t          state;
    acc_t            acc;
    logic [9:0]      ms_q;
    logic [5:0]      s_q;
    logic [5:0]      min_q;
    logic [3:0]      hr_q;
    logic            range_err;

    logic            in_err;
    acc_t            r;
    logic [AW+BITS-1:0] r_ext;
    logic            r_ovf;

    always_comb begin
        in_err = (ms > 10'd999) || (s > 6'd59) || (min > 6'd59);
        // acc*1000 as acc*1024 - acc*16 - acc*8
        r      = (acc << 10) - (acc << 4) - (acc << 3) + acc_t'(ms_q);
        r_ext  = {{BITS{1'b0}}, r};
        r_ovf  = |(r_ext >> BITS);
    end

    // NOTE: every register here is updated with <= so that all stages read the
    // values from before the edge; blocking assignments would chain the stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            ms_q      <= '0;
            s_q       <= '0;
            min_q     <= '0;
            hr_q      <= '0;
            range_err <= 1'b0;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ms_q      <= ms;
                        s_q       <= s;
                        min_q     <= min;
                        hr_q      <= hr;
                        range_err <= in_err;
                        busy      <= 1'b1;
                        state     <= HM;
                    end
                end
                HM: begin
                    acc   <= (acc_t'(hr_q) << 6) - (acc_t'(hr_q) << 2) + acc_t'(min_q);
                    state <= HMS;
                end
                HMS: begin
                    acc   <= (acc << 6) - (acc << 2) + acc_t'(s_q);
                    state <= MSEC;
                end
                MSEC: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    err   <= range_err;
                    state <= IDLE;
                    // A rejected conversion leaves the previous count visible.
                    if (range_err) begin
                        ovf <= 1'b0;
                    end else begin
                        ovf <= r_ovf;
`ifdef WATCH2COUNT_SATURATE_EN
                        count <= r_ovf ? {BITS{1'b1}} : r_ext[BITS-1:0];
`else
                        count <= r_ext[BITS-1:0];
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_watch2count.sv
// Randomized self-checking bench for watch2count: a 26-bit and a 16-bit instance share stimulus
// and are compared against an arithmetic model of the time-to-milliseconds conversion.
module tb_watch2count;

    localparam int BITS  = 26;
    localparam int NBITS = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [9:0]       ms;
    logic [5:0]       s;
    logic [5:0]       min;
    logic [3:0]       hr;

    logic [BITS-1:0]  count;
    logic             busy, done, err, ovf;
    logic [NBITS-1:0] count16;
    logic             busy16, done16, err16, ovf16;

    int n_vec  = 0;
    int n_miss = 0;

    longint exp_count   = 0;
    longint exp_count16 = 0;
    bit     exp_err     = 0;
    bit     exp_ovf     = 0;
    bit     exp_ovf16   = 0;

    watch2count #(.BITS(BITS)) dut (
        .clk(clk), .reset(reset), .start(start),
        .ms(ms), .s(s), .min(min), .hr(hr),
        .count(count), .busy(busy), .done(done), .err(err), .ovf(ovf)
    );

    watch2count #(.BITS(NBITS)) dut16 (
        .clk(clk), .reset(reset), .start(start),
        .ms(ms), .s(s), .min(min), .hr(hr),
        .count(count16), .busy(busy16), .done(done16), .err(err16), .ovf(ovf16)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Fit a full-precision result into a w-bit count.
    task automatic fit(input longint r, input int w, inout longint cnt, output bit o);
        longint maxv;
        maxv = (longint'(1) << w) - 1;
        o = (r > maxv);
        if (!o)
            cnt = r;
        else begin
`ifdef WATCH2COUNT_SATURATE_EN
            cnt = maxv;
`else
            cnt = r % (maxv + 1);
`endif
        end
    endtask

    task automatic model(input int h, input int m, input int sec, input int msec);
        longint r;
        r = ((longint'(h) * 60 + m) * 60 + sec) * 1000 + msec;
        exp_err = (msec > 999) || (sec > 59) || (m > 59);
        if (exp_err) begin
            exp_ovf   = 0;
            exp_ovf16 = 0;
        end else begin
            fit(r, BITS, exp_count, exp_ovf);
            fit(r, NBITS, exp_count16, exp_ovf16);
        end
    endtask

    task automatic check_result(input string tag);
        check({tag, ".done"},    done,    1);
        check({tag, ".busy"},    busy,    0);
        check({tag, ".count"},   count,   exp_count);
        check({tag, ".err"},     err,     exp_err);
        check({tag, ".ovf"},     ovf,     exp_ovf);
        check({tag, ".done16"},  done16,  1);
        check({tag, ".count16"}, count16, exp_count16);
        check({tag, ".err16"},   err16,   exp_err);
        check({tag, ".ovf16"},   ovf16,   exp_ovf16);
    endtask

    task automatic scramble();
        hr  = 4'($urandom);
        min = 6'($urandom);
        s   = 6'($urandom);
        ms  = 10'($urandom);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the done edge.
    task automatic convert(input int h, input int m, input int sec, input int msec, input string tag);
        hr    = 4'(h);
        min   = 6'(m);
        s     = 6'(sec);
        ms    = 10'(msec);
        start = 1'b1;
        model(h, m, sec, msec);
        @(negedge clk);
        start = 1'b0;
        scramble();
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            check({tag, ".busy_run"}, busy, 1);
            check({tag, ".done_early"}, done, 0);
        end
        @(negedge clk);
        check_result(tag);
    endtask

    initial begin
        int h, m, sec, msec;

        reset = 1'b1;
        start = 1'b0;
        hr = '0; min = '0; s = '0; ms = '0;
        repeat (2) @(negedge clk);
        check("rst.count", count, 0);
        check("rst.busy",  busy,  0);
        check("rst.done",  done,  0);
        check("rst.err",   err,   0);
        check("rst.ovf",   ovf,   0);
        reset = 1'b0;
        @(negedge clk);

        convert(1, 2, 3, 456, "t1");
        convert(9, 59, 59, 999, "t_9h");
        convert(15, 59, 59, 999, "t_max");
        convert(1, 2, 3, 456, "t_pre");
        convert(0, 0, 60, 0, "t_err_s");
        convert(0, 0, 0, 0, "t_zero");
        convert(0, 1, 5, 536, "t_65536");
        convert(0, 60, 0, 0, "t_err_min");
        convert(0, 0, 0, 1000, "t_err_ms");
        convert(2, 0, 0, 0, "t_clr");
        @(negedge clk);
        check("done_pulse_width", done, 0);

        for (int i = 0; i < 20; i++) begin
            h    = int'($urandom_range(0, 15));
            m    = int'($urandom_range(0, 63));
            sec  = int'($urandom_range(0, 63));
            msec = int'($urandom_range(0, 1023));
            convert(h, m, sec, msec, $sformatf("rnd%0d", i));
        end

        // start held high: conversions accepted at every fourth edge only
        for (int i = 0; i <= 16; i++) begin
            if (i >= 1) begin
                if (i % 4 == 0)
                    check_result($sformatf("stream%0d", i));
                else begin
                    check("stream.busy", busy, 1);
                    check("stream.done", done, 0);
                end
            end
            if (i == 16) break;
            h    = int'($urandom_range(0, 15));
            m    = int'($urandom_range(0, 63));
            sec  = int'($urandom_range(0, 63));
            msec = int'($urandom_range(0, 1023));
            hr = 4'(h); min = 6'(m); s = 6'(sec); ms = 10'(msec);
            start = 1'b1;
            if (i % 4 == 0) model(h, m, sec, msec);
            @(negedge clk);
        end
        start = 1'b0;

        // asynchronous reset in the middle of a conversion
        convert(3, 4, 5, 6, "t_before_rst");
        hr = 4'd1; min = 6'd2; s = 6'd3; ms = 10'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst.count",   count,   0);
        check("arst.busy",    busy,    0);
        check("arst.done",    done,    0);
        check("arst.err",     err,     0);
        check("arst.ovf",     ovf,     0);
        check("arst.count16", count16, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_count = 0; exp_count16 = 0; exp_err = 0; exp_ovf = 0; exp_ovf16 = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("arst.no_done", done, 0);
            check("arst.idle", busy, 0);
        end
        check("arst.count_kept", count, 0);
        convert(1, 2, 3, 456, "t_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
